// File: rtl/iter_divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and result-width helper,
// also used by the EX-stage stall logic.
package iter_divider_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Packed {quotient, remainder} width for a given operand width
   function automatic int unsigned div_result_w(input int unsigned width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/iter_divider_nr_step.sv
// One radix-2 non-restoring iteration: shift {rem, dividend} left, add or subtract the
// divisor on the old remainder sign, emit one quotient bit.
module nr_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH:0]   o_rem_c,
   output logic [WIDTH-1:0] o_quo_c
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_dvs_ext;

   // Dropping rem's MSB keeps the shift exact modulo 2^(WIDTH+1); the result is back in range
   assign w_shift   = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
   assign w_dvs_ext = {1'b0, i_dvs};
   assign o_rem_c   = i_rem[WIDTH] ? (w_shift + w_dvs_ext) : (w_shift - w_dvs_ext);
   assign o_quo_c   = {i_quo[WIDTH-2:0], ~o_rem_c[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 non-restoring divider with start/done handshake, signed/unsigned
// modes, RISC-V divide-by-zero / overflow results and pipeline flush.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               div_en,
   input  logic               signed_en,
   input  logic               flush,
   input  logic [WIDTH-1:0]   operand_1,
   input  logic [WIDTH-1:0]   operand_2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_zero
);

   localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
   localparam int unsigned      RES_W   = div_result_w(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       r_state,    w_state_nxt;
   logic [WIDTH:0]   r_rem,      w_rem_nxt;
   logic [WIDTH-1:0] r_quo,      w_quo_nxt;
   logic [WIDTH-1:0] r_dvs,      w_dvs_nxt;
   logic             r_neg_q,    w_neg_q_nxt;
   logic             r_neg_r,    w_neg_r_nxt;
   logic             r_dz,       w_dz_nxt;
   logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
   logic             r_busy,     w_busy_nxt;
   logic             r_done,     w_done_nxt;
   logic             r_div_zero, w_div_zero_nxt;
   logic [RES_W-1:0] r_result,   w_result_nxt;

   logic             w_accept;
   logic             w_op1_neg;
   logic             w_op2_neg;
   logic             w_div0;
   logic             w_ovf;
   logic [WIDTH-1:0] w_mag1;
   logic [WIDTH-1:0] w_mag2;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;
   logic [WIDTH:0]   w_step_rem;
   logic [WIDTH-1:0] w_step_quo;

   nr_div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem   (r_rem),
      .i_quo   (r_quo),
      .i_dvs   (r_dvs),
      .o_rem_c (w_step_rem),
      .o_quo_c (w_step_quo)
   );

   assign w_accept  = div_en & ~flush & ((r_state == DIV_IDLE) | (r_state == DIV_DONE));
   assign w_op1_neg = signed_en & operand_1[WIDTH-1];
   assign w_op2_neg = signed_en & operand_2[WIDTH-1];
   assign w_mag1    = w_op1_neg ? WIDTH'(-operand_1) : operand_1;
   assign w_mag2    = w_op2_neg ? WIDTH'(-operand_2) : operand_2;
   assign w_div0    = (operand_2 == '0);
   assign w_ovf     = signed_en & (operand_1 == MIN_VAL) & (operand_2 == '1);
   assign w_quo_fix = r_neg_q ? WIDTH'(-r_quo) : r_quo;
   assign w_rem_fix = r_neg_r ? WIDTH'(-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

   // Next-state and datapath update
   always_comb begin
      w_state_nxt    = r_state;
      w_rem_nxt      = r_rem;
      w_quo_nxt      = r_quo;
      w_dvs_nxt      = r_dvs;
      w_neg_q_nxt    = r_neg_q;
      w_neg_r_nxt    = r_neg_r;
      w_dz_nxt       = r_dz;
      w_cnt_nxt      = r_cnt;
      w_result_nxt   = r_result;
      w_div_zero_nxt = r_div_zero;

      if (flush) begin
         w_state_nxt = DIV_IDLE;
      end else begin
         case (r_state)
            DIV_IDLE, DIV_DONE: begin
               if (w_accept) begin
                  w_cnt_nxt   = '0;
                  w_dvs_nxt   = w_mag2;
                  w_quo_nxt   = w_mag1;
                  w_rem_nxt   = '0;
                  w_neg_q_nxt = w_op1_neg ^ w_op2_neg;
                  w_neg_r_nxt = w_op1_neg;
                  w_dz_nxt    = 1'b0;
                  w_state_nxt = DIV_CALC;
                  // Special results are preloaded unsigned and pass straight through FIX
                  if (w_div0) begin
                     w_quo_nxt   = '1;
                     w_rem_nxt   = {1'b0, operand_1};
                     w_neg_q_nxt = 1'b0;
                     w_neg_r_nxt = 1'b0;
                     w_dz_nxt    = 1'b1;
                     w_state_nxt = DIV_FIX;
                  end else if (w_ovf) begin
                     w_quo_nxt   = MIN_VAL;
                     w_rem_nxt   = '0;
                     w_neg_q_nxt = 1'b0;
                     w_neg_r_nxt = 1'b0;
                     w_state_nxt = DIV_FIX;
                  end
               end else begin
                  w_state_nxt = DIV_IDLE;
               end
            end
            DIV_CALC: begin
               // WIDTH iterations, then one cycle restoring a negative remainder
               if (r_cnt == CNT_W'(WIDTH)) begin
                  if (r_rem[WIDTH]) begin
                     w_rem_nxt = r_rem + {1'b0, r_dvs};
                  end
                  w_state_nxt = DIV_FIX;
               end else begin
                  w_rem_nxt = w_step_rem;
                  w_quo_nxt = w_step_quo;
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            DIV_FIX: begin
               w_result_nxt   = {w_quo_fix, w_rem_fix};
               w_div_zero_nxt = r_dz;
               w_state_nxt    = DIV_DONE;
            end
            default: begin
               w_state_nxt = DIV_IDLE;
            end
         endcase
      end

      w_busy_nxt = (w_state_nxt == DIV_CALC) | (w_state_nxt == DIV_FIX);
      w_done_nxt = (w_state_nxt == DIV_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= DIV_IDLE;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_div_zero <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rem      <= w_rem_nxt;
         r_quo      <= w_quo_nxt;
         r_dvs      <= w_dvs_nxt;
         r_neg_q    <= w_neg_q_nxt;
         r_neg_r    <= w_neg_r_nxt;
         r_dz       <= w_dz_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_result   <= w_result_nxt;
         r_div_zero <= w_div_zero_nxt;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_iter_divider.sv
// Randomised and directed checks of iter_divider (WIDTH=32 and WIDTH=8) against an
// arithmetic reference model.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en32, en8, sgn, flush;
   logic [31:0] a32, b32;
   logic [7:0]  a8, b8;
   logic        busy32, done32, dz32;
   logic        busy8, done8, dz8;
   logic [63:0] res32;
   logic [15:0] res8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iter_divider #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .div_en(en32), .signed_en(sgn), .flush(flush),
      .operand_1(a32), .operand_2(b32), .busy(busy32), .done(done32),
      .result(res32), .div_zero(dz32)
   );

   iter_divider #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .div_en(en8), .signed_en(sgn), .flush(flush),
      .operand_1(a8), .operand_2(b8), .busy(busy8), .done(done8),
      .result(res8), .div_zero(dz8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // RISC-V division semantics on w-bit operands, packed {q, r} in the low 2*w bits
   function automatic logic [63:0] ref_div(input int unsigned w, input bit s,
                                           input logic [31:0] a, input logic [31:0] b);
      longint mask, ua, ub, sa, sb, q, r, mn;
      mask = (longint'(1) << w) - 1;
      ua   = longint'({32'd0, a}) & mask;
      ub   = longint'({32'd0, b}) & mask;
      sa   = (s && ua[w-1]) ? ua - (longint'(1) << w) : ua;
      sb   = (s && ub[w-1]) ? ub - (longint'(1) << w) : ub;
      mn   = -(longint'(1) << (w - 1));
      if (ub == 0) begin
         q = mask;
         r = ua;
      end else if (s && sa == mn && sb == -1) begin
         q = mn;
         r = 0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      return 64'(((q & mask) << w) | (r & mask));
   endfunction

   function automatic bit is_special(input int unsigned w, input bit s,
                                     input logic [31:0] a, input logic [31:0] b);
      longint mask, ua, ub;
      mask = (longint'(1) << w) - 1;
      ua   = longint'({32'd0, a}) & mask;
      ub   = longint'({32'd0, b}) & mask;
      return (ub == 0) || (s && ua == (longint'(1) << (w - 1)) && ub == mask);
   endfunction

   task automatic run_op(input bit w8, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
      int unsigned w;
      logic [63:0] exp_res;
      int          exp_lat, cyc, bcnt;
      bit          exp_dz;
      w       = w8 ? 8 : 32;
      exp_res = ref_div(w, s, a, b);
      exp_lat = is_special(w, s, a, b) ? 1 : int'(w) + 2;
      exp_dz  = w8 ? (b[7:0] == 8'd0) : (b == 32'd0);
      @(negedge clk);
      sgn = s;
      if (w8) begin
         en8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         en32 = 1'b1; a32 = a; b32 = b;
      end
      @(posedge clk);
      #1;
      en8 = 1'b0; en32 = 1'b0;
      a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
      sgn = 1'($urandom);
      cyc = 0; bcnt = 0;
      while (!(w8 ? done8 : done32) && cyc < 200) begin
         if (w8 ? busy8 : busy32) bcnt++;
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_lat));
      chk({tag, " result"}, w8 ? 64'(res8) : res32, exp_res);
      chk({tag, " div_zero"}, 64'(w8 ? dz8 : dz32), 64'(exp_dz));
      @(posedge clk);
      #1;
      chk({tag, " done_width"}, 64'(w8 ? done8 : done32), 64'd0);
   endtask

   initial begin
      logic [63:0] prev_res;
      logic        prev_dz;
      bit          seen;
      int          cyc;
      logic [31:0] ra, rb;
      bit          rs;
      int          mode;

      rst_n = 1'b0; en32 = 1'b0; en8 = 1'b0; sgn = 1'b0; flush = 1'b0;
      a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy32), 64'd0);
      chk("reset done", 64'(done32), 64'd0);
      chk("reset result", res32, 64'd0);
      chk("reset div_zero", 64'(dz32), 64'd0);
      chk("reset result8", 64'(res8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      run_op(1'b0, 1'b0, 32'd100, 32'd7, "u100_7");
      chk("u100_7 const", res32, {32'd14, 32'd2});
      run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, "s-7_2");
      chk("s-7_2 const", res32, {32'hFFFFFFFD, 32'hFFFFFFFF});
      run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, "s7_-2");
      chk("s7_-2 const", res32, {32'hFFFFFFFD, 32'd1});
      run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, "uMAX_2");
      chk("uMAX_2 const", res32, {32'h7FFFFFFF, 32'd1});
      run_op(1'b0, 1'b0, 32'd5, 32'd0, "u5_0");
      chk("u5_0 const", res32, {32'hFFFFFFFF, 32'd5});
      run_op(1'b0, 1'b1, 32'd5, 32'd0, "s5_0");
      run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, "sMIN_-1");
      chk("sMIN_-1 const", res32, {32'h80000000, 32'd0});
      run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, "uMIN_MAX");
      chk("uMIN_MAX const", res32, {32'd0, 32'h80000000});

      // Flush mid-operation, div_en while busy and together with flush
      prev_res = res32;
      prev_dz  = dz32;
      @(negedge clk);
      sgn = 1'b0; en32 = 1'b1; a32 = 32'd1000; b32 = 32'd3;
      @(posedge clk);
      #1;
      a32 = 32'd77; b32 = 32'd5;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; en32 = 1'b0;
      chk("flush busy", 64'(busy32), 64'd0);
      seen = 1'b0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (done32) seen = 1'b1;
      end
      chk("flush no_done", 64'(seen), 64'd0);
      chk("flush result_kept", res32, prev_res);
      chk("flush div_zero_kept", 64'(dz32), 64'(prev_dz));
      run_op(1'b0, 1'b0, 32'd9, 32'd3, "post_flush");
      chk("post_flush const", res32, {32'd3, 32'd0});

      // Asynchronous reset mid-operation
      @(negedge clk);
      en32 = 1'b1; a32 = 32'd1000; b32 = 32'd3;
      @(posedge clk);
      #1;
      en32 = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst busy", 64'(busy32), 64'd0);
      chk("rst done", 64'(done32), 64'd0);
      chk("rst result", res32, 64'd0);
      chk("rst div_zero", 64'(dz32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (done32) seen = 1'b1;
      end
      chk("rst no_done", 64'(seen), 64'd0);

      // Back-to-back: div_en held high through DONE
      @(negedge clk);
      sgn = 1'b0; en32 = 1'b1; a32 = 32'd50; b32 = 32'd6;
      @(posedge clk);
      #1;
      a32 = 32'd200; b32 = 32'd9;
      cyc = 0;
      while (!done32 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("b2b first latency", 64'(cyc), 64'd34);
      chk("b2b first result", res32, ref_div(32, 1'b0, 32'd50, 32'd6));
      chk("b2b busy_in_done", 64'(busy32), 64'd0);
      @(posedge clk);
      #1;
      en32 = 1'b0;
      chk("b2b second accepted", 64'(busy32), 64'd1);
      cyc = 0;
      while (!done32 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("b2b second latency", 64'(cyc), 64'd34);
      chk("b2b second result", res32, ref_div(32, 1'b0, 32'd200, 32'd9));

      // Random sweeps, both widths and modes, with forced corner cases
      for (int i = 0; i < 60; i++) begin
         mode = int'($urandom_range(0, 9));
         rs   = 1'($urandom);
         ra   = $urandom;
         rb   = $urandom;
         if (mode == 0) rb = 32'd0;
         if (mode == 1) begin ra = 32'h80; rb = 32'hFF; end
         run_op(1'b1, rs, ra, rb, "rnd8");
      end
      for (int i = 0; i < 30; i++) begin
         mode = int'($urandom_range(0, 9));
         rs   = 1'($urandom);
         ra   = $urandom;
         rb   = (mode < 5) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (mode == 0) rb = 32'd0;
         if (mode == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
         run_op(1'b0, rs, ra, rb, "rnd32");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
